// File: rtl/alu_ctrl_seq.sv
// Registered EX-stage ALU control decoder with MULT/DIV sequencing and hazard stall.
// Optional build macro: ALUCTRL_ILLEGAL_TRAP_EN (illegal ops trap to all-ones with sticky illegalOUT).
module alu_ctrl_seq #(
    parameter int OP_W      = 4,
    parameter int FUNCT_W   = 6,
    parameter int CTRL_W    = 5,
    parameter int MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               validIN,
    input  logic               stallIN,
    input  logic [OP_W-1:0]    controlIN,
    input  logic [FUNCT_W-1:0] functIN,
    output logic [CTRL_W-1:0]  aLUControl,
    output logic               validOUT,
    output logic               mdStart,
    output logic               mdBusy,
    output logic               mdDone,
    output logic               stallOUT,
    output logic               illegalOUT
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    localparam logic [CTRL_W-1:0] SEL_AND  = CTRL_W'(5'b00000);
    localparam logic [CTRL_W-1:0] SEL_OR   = CTRL_W'(5'b00001);
    localparam logic [CTRL_W-1:0] SEL_ADD  = CTRL_W'(5'b00010);
    localparam logic [CTRL_W-1:0] SEL_XOR  = CTRL_W'(5'b00011);
    localparam logic [CTRL_W-1:0] SEL_SUB  = CTRL_W'(5'b00110);
    localparam logic [CTRL_W-1:0] SEL_SLT  = CTRL_W'(5'b00111);
    localparam logic [CTRL_W-1:0] SEL_SLL  = CTRL_W'(5'b01000);
    localparam logic [CTRL_W-1:0] SEL_SRL  = CTRL_W'(5'b01001);
    localparam logic [CTRL_W-1:0] SEL_LUI  = CTRL_W'(5'b01010);
    localparam logic [CTRL_W-1:0] SEL_SLTU = CTRL_W'(5'b01011);
    localparam logic [CTRL_W-1:0] SEL_NOR  = CTRL_W'(5'b01100);
    localparam logic [CTRL_W-1:0] SEL_MFHI = CTRL_W'(5'b01101);
    localparam logic [CTRL_W-1:0] SEL_MFLO = CTRL_W'(5'b01110);
    localparam logic [CTRL_W-1:0] SEL_MULT = CTRL_W'(5'b10000);
    localparam logic [CTRL_W-1:0] SEL_DIV  = CTRL_W'(5'b10001);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mdState_e;

    mdState_e           state_r;
    logic [CNT_W-1:0]   count_r;
    logic [CTRL_W:0]    decoded_s;
    logic [CTRL_W-1:0]  selNext_s;
    logic               illegalDec_s;
    logic               isMd_s;
    logic               isHl_s;
    logic               accept_s;

    // Result is {illegal, select}; illegal entries carry the add select.
    function automatic logic [CTRL_W:0] decodeFunct(input logic [FUNCT_W-1:0] fn);
        logic [CTRL_W:0] res;
        case (fn)
            FUNCT_W'(6'b100000): res = {1'b0, SEL_ADD};
            FUNCT_W'(6'b100010): res = {1'b0, SEL_SUB};
            FUNCT_W'(6'b100100): res = {1'b0, SEL_AND};
            FUNCT_W'(6'b100101): res = {1'b0, SEL_OR};
            FUNCT_W'(6'b100110): res = {1'b0, SEL_XOR};
            FUNCT_W'(6'b100111): res = {1'b0, SEL_NOR};
            FUNCT_W'(6'b101010): res = {1'b0, SEL_SLT};
            FUNCT_W'(6'b000000): res = {1'b0, SEL_SLL};
            FUNCT_W'(6'b000010): res = {1'b0, SEL_SRL};
            FUNCT_W'(6'b010000): res = {1'b0, SEL_MFHI};
            FUNCT_W'(6'b010010): res = {1'b0, SEL_MFLO};
            FUNCT_W'(6'b011000): res = {1'b0, SEL_MULT};
            FUNCT_W'(6'b011010): res = {1'b0, SEL_DIV};
            default:             res = {1'b1, SEL_ADD};
        endcase
        return res;
    endfunction

    function automatic logic [CTRL_W:0] decodeOp(input logic [OP_W-1:0] op,
                                                 input logic [FUNCT_W-1:0] fn);
        logic [CTRL_W:0] res;
        case (op)
            OP_W'(4'b0000): res = {1'b0, SEL_ADD};
            OP_W'(4'b0001): res = {1'b0, SEL_SUB};
            OP_W'(4'b0010): res = decodeFunct(fn);
            OP_W'(4'b0011): res = {1'b0, SEL_AND};
            OP_W'(4'b0100): res = {1'b0, SEL_OR};
            OP_W'(4'b0101): res = {1'b0, SEL_SLT};
            OP_W'(4'b0110): res = {1'b0, SEL_XOR};
            OP_W'(4'b0111): res = {1'b0, SEL_LUI};
            OP_W'(4'b1000): res = {1'b0, SEL_SLTU};
            OP_W'(4'b1001): res = {1'b0, SEL_SUB};
            OP_W'(4'b1010): res = {1'b0, SEL_SUB};
            OP_W'(4'b1011): res = {1'b0, SEL_NOR};
            default:        res = {1'b1, SEL_ADD};
        endcase
        return res;
    endfunction

    // Decode, hazard detection and accept qualification.
    always_comb begin
        decoded_s    = decodeOp(controlIN, functIN);
        illegalDec_s = decoded_s[CTRL_W];
        selNext_s    = decoded_s[CTRL_W-1:0];
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
        if (illegalDec_s) begin
            selNext_s = {CTRL_W{1'b1}};
        end else begin
            selNext_s = decoded_s[CTRL_W-1:0];
        end
`endif
        isMd_s   = (selNext_s == SEL_MULT) || (selNext_s == SEL_DIV);
        isHl_s   = (selNext_s == SEL_MFHI) || (selNext_s == SEL_MFLO);
        stallOUT = validIN & (isMd_s | isHl_s) & (state_r != IDLE);
        accept_s = validIN & ~stallIN & ~stallOUT;
    end

    // Output register: load on accept, freeze under downstream stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            aLUControl <= {CTRL_W{1'b0}};
            validOUT   <= 1'b0;
        end else if (stallIN) begin
            aLUControl <= aLUControl;
            validOUT   <= validOUT;
        end else if (accept_s) begin
            aLUControl <= selNext_s;
            validOUT   <= 1'b1;
        end else begin
            aLUControl <= aLUControl;
            validOUT   <= 1'b0;
        end
    end

    // Sticky illegal-op flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegalOUT <= 1'b0;
        end else begin
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
            illegalOUT <= illegalOUT | (accept_s & illegalDec_s);
`else
            illegalOUT <= 1'b0;
`endif
        end
    end

    // MULT/DIV sequencer; the countdown runs regardless of stallIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= {CNT_W{1'b0}};
            mdStart <= 1'b0;
            mdBusy  <= 1'b0;
            mdDone  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mdDone <= 1'b0;
                    if (accept_s && isMd_s) begin
                        state_r <= RUN;
                        count_r <= CNT_W'(MD_CYCLES - 1);
                        mdStart <= 1'b1;
                        mdBusy  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        mdStart <= 1'b0;
                        mdBusy  <= 1'b0;
                    end
                end
                RUN: begin
                    mdStart <= 1'b0;
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_r <= DONE;
                        mdBusy  <= 1'b0;
                        mdDone  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        count_r <= count_r - CNT_W'(1);
                        mdBusy  <= 1'b1;
                        mdDone  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    mdStart <= 1'b0;
                    mdBusy  <= 1'b0;
                    mdDone  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= {CNT_W{1'b0}};
                    mdStart <= 1'b0;
                    mdBusy  <= 1'b0;
                    mdDone  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus pushes expected selects, a negedge monitor pops them.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       validIN;
    logic       stallIN;
    logic [3:0] controlIN;
    logic [5:0] functIN;
    logic [4:0] aLUControl;
    logic       validOUT, mdStart, mdBusy, mdDone, stallOUT, illegalOUT;

    int         checks = 0;
    int         failures = 0;
    logic [4:0] expQ[$];
    logic [4:0] monExp;
    logic       heldAtEdge = 1'b1;

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
    localparam logic [4:0] ILL_SEL = 5'b11111;
    localparam logic       ILL_FLAG = 1'b1;
`else
    localparam logic [4:0] ILL_SEL = 5'b00010;
    localparam logic       ILL_FLAG = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_ctrl_seq dut (
        .clk(clk), .reset(reset), .validIN(validIN), .stallIN(stallIN),
        .controlIN(controlIN), .functIN(functIN), .aLUControl(aLUControl),
        .validOUT(validOUT), .mdStart(mdStart), .mdBusy(mdBusy), .mdDone(mdDone),
        .stallOUT(stallOUT), .illegalOUT(illegalOUT)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Records whether the output register was frozen at the last edge.
    always @(posedge clk) heldAtEdge = stallIN | reset;

    // Monitor: every freshly loaded valid output consumes one expected entry.
    always @(negedge clk) begin
        if (validOUT === 1'b1 && !heldAtEdge) begin
            if (expQ.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                monExp = expQ.pop_front();
                check("aluctrl", {27'd0, aLUControl}, {27'd0, monExp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [5:0] f, input logic [4:0] e);
        validIN = 1'b1; controlIN = c; functIN = f;
        expQ.push_back(e);
        #1;
        check("no_stall_on_issue", {31'd0, stallOUT}, 32'd0);
        step();
        validIN = 1'b0;
    endtask

    logic [4:0] opTbl[12] = '{5'b00010, 5'b00110, 5'b00010, 5'b00000, 5'b00001, 5'b00111,
                              5'b00011, 5'b01010, 5'b01011, 5'b00110, 5'b00110, 5'b01100};
    logic [5:0] fnTbl[13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                              6'b101010, 6'b000000, 6'b000010, 6'b010000, 6'b010010, 6'b000001,
                              6'b111111};
    logic [4:0] fnExp[13] = '{5'b00010, 5'b00110, 5'b00000, 5'b00001, 5'b00011, 5'b01100,
                              5'b00111, 5'b01000, 5'b01001, 5'b01101, 5'b01110, ILL_SEL,
                              ILL_SEL};
    logic [3:0] stallOps[3] = '{4'b0001, 4'b0011, 4'b0100};

    initial begin
        int busy, guard, stallCycles, doneCount;
        logic prevDone;
        reset = 1'b1; validIN = 1'b0; stallIN = 1'b0; controlIN = 4'd0; functIN = 6'd0;
        step(); step();
        check("rst_alu", {27'd0, aLUControl}, 32'd0);
        check("rst_valid", {31'd0, validOUT}, 32'd0);
        check("rst_md", {29'd0, mdStart, mdBusy, mdDone}, 32'd0);
        check("rst_illegal", {31'd0, illegalOUT}, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) issue(4'(i), 6'b100000, opTbl[i]);
        for (int i = 0; i < 13; i++) issue(4'b0010, fnTbl[i], fnExp[i]);
        step();
        check("valid_drops_idle", {31'd0, validOUT}, 32'd0);
        check("alu_holds_idle", {27'd0, aLUControl}, {27'd0, ILL_SEL});

        // Multiply: 32 busy cycles, done pulse, then mfhi.
        issue(4'b0010, 6'b011000, 5'b10000);
        check("mult_start", {31'd0, mdStart}, 32'd1);
        busy = 0; guard = 0;
        while (mdBusy === 1'b1 && guard < 100) begin
            busy++; guard++;
            step();
        end
        check("mult_busy_cycles", busy, 32);
        check("mult_done_pulse", {31'd0, mdDone}, 32'd1);
        step();
        check("mult_done_one_cycle", {31'd0, mdDone}, 32'd0);
        issue(4'b0010, 6'b010000, 5'b01101);

        // Divide: add flows during RUN, mflo stalls until the cycle after mdDone.
        issue(4'b0010, 6'b011010, 5'b10001);
        issue(4'b0000, 6'b000000, 5'b00010);
        validIN = 1'b1; controlIN = 4'b0010; functIN = 6'b010010;
        #1;
        check("mflo_stall_run", {31'd0, stallOUT}, 32'd1);
        stallCycles = 1; prevDone = 1'b0; guard = 0;
        while (stallOUT === 1'b1 && guard < 100) begin
            prevDone = mdDone;
            guard++;
            step();
            if (stallOUT === 1'b1) stallCycles++;
        end
        check("mflo_stall_cycles", stallCycles, 32);
        check("stall_through_done", {31'd0, prevDone}, 32'd1);
        check("idle_after_done", {30'd0, mdBusy, mdDone}, 32'd0);
        expQ.push_back(5'b01110);
        step();
        validIN = 1'b0;

        // Downstream stall freezes the output; last presented op wins.
        issue(4'b0101, 6'b100000, 5'b00111);
        stallIN = 1'b1; validIN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            controlIN = stallOps[k];
            step();
            check("stall_hold_alu", {27'd0, aLUControl}, 32'h07);
            check("stall_hold_valid", {31'd0, validOUT}, 32'd1);
        end
        stallIN = 1'b0;
        expQ.push_back(5'b00001);
        step();
        validIN = 1'b0;

        // Reset in the middle of a divide abandons it.
        issue(4'b0010, 6'b011010, 5'b10001);
        repeat (10) step();
        check("div_busy_mid", {31'd0, mdBusy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_outputs", {23'd0, aLUControl, validOUT, mdStart, mdBusy, mdDone}, 32'd0);
        doneCount = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (mdDone === 1'b1 || mdBusy === 1'b1) doneCount++;
        end
        check("no_done_after_rst", doneCount, 0);

        // Illegal op handling and stickiness.
        issue(4'b1101, 6'b100000, ILL_SEL);
        check("illegal_flag", {31'd0, illegalOUT}, {31'd0, ILL_FLAG});
        issue(4'b0000, 6'b100000, 5'b00010);
        check("illegal_sticky", {31'd0, illegalOUT}, {31'd0, ILL_FLAG});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("illegal_cleared", {31'd0, illegalOUT}, 32'd0);

        step(); step();
        check("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
